// File: rtl/mem_access_ctrl_if.sv
`default_nettype none
// ============================================================
// Interface : mem_access_ctrl_if
// Request/response and memory-port bundle for mem_access_ctrl.
// Rev       : 1.0
// ============================================================
interface mem_access_ctrl_if #(
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32
);
  logic                  REQ_VALID;
  logic                  REQ_READ;
  logic                  REQ_WRITE;
  logic [ADDR_WIDTH-1:0] REQ_ADDR;
  logic [DATA_WIDTH-1:0] REQ_WDATA;
  logic                  BUSY;
  logic                  RSP_VALID;
  logic [DATA_WIDTH-1:0] RSP_RDATA;
  logic                  RSP_ERR;
  logic                  MEM_CS;
  logic                  MEM_WE;
  logic [ADDR_WIDTH-1:0] MEM_ADDR;
  logic [DATA_WIDTH-1:0] MEM_WDATA;
  logic [DATA_WIDTH-1:0] MEM_RDATA;
  logic                  MEM_ACK;

  // Controller side
  modport slave (
    input  REQ_VALID, REQ_READ, REQ_WRITE, REQ_ADDR, REQ_WDATA,
    input  MEM_RDATA, MEM_ACK,
    output BUSY, RSP_VALID, RSP_RDATA, RSP_ERR,
    output MEM_CS, MEM_WE, MEM_ADDR, MEM_WDATA
  );

  // Control-unit plus memory side
  modport master (
    output REQ_VALID, REQ_READ, REQ_WRITE, REQ_ADDR, REQ_WDATA,
    output MEM_RDATA, MEM_ACK,
    input  BUSY, RSP_VALID, RSP_RDATA, RSP_ERR,
    input  MEM_CS, MEM_WE, MEM_ADDR, MEM_WDATA
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================
// Module : mem_access_ctrl
// Turns single-cycle CPU requests into a timeout-guarded memory handshake.
// Rev    : 1.0
// ============================================================
module mem_access_ctrl #(
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic             CLK,
  input  logic             RST,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  // Last WAIT cycle is the one where the counter shows TIMEOUT-1
  localparam logic [7:0] c_cnt_last = 8'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        // Read and write both set (or neither) is the control unit's no-op
        if (bus.REQ_VALID && (bus.REQ_READ ^ bus.REQ_WRITE)) begin
          addr_d  = bus.REQ_ADDR;
          wdata_d = bus.REQ_WDATA;
          we_d    = bus.REQ_WRITE;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = 8'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (bus.MEM_ACK) begin
          state_d = S_DONE;
          if (!we_q) begin
            rdata_d = bus.MEM_RDATA;
          end
        end else if (cnt_q == c_cnt_last) begin
          state_d = S_ERR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.BUSY      = (state_q != S_IDLE);
  assign bus.MEM_CS    = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign bus.MEM_WE    = we_q;
  assign bus.MEM_ADDR  = addr_q;
  assign bus.MEM_WDATA = wdata_q;
  assign bus.RSP_VALID = (state_q == S_DONE) || (state_q == S_ERR);
  assign bus.RSP_ERR   = (state_q == S_ERR);
  assign bus.RSP_RDATA = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================
// Module : tb_mem_access_ctrl
// Scoreboard bench for mem_access_ctrl acting as control unit and memory.
// Rev    : 1.0
// ============================================================
module tb_mem_access_ctrl;
  localparam int AW = 26;
  localparam int DW = 32;
  localparam int TO = 16;

  typedef struct {
    logic          err;
    logic [DW-1:0] rdata;
  } sb_entry_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  sb_entry_t     sb[$];
  logic [DW-1:0] exp_rdata;

  mem_access_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_access_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Response monitor: every RSP_VALID pulse must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.RSP_VALID === 1'b1) begin
      sb_entry_t e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got RSP_VALID with err=%b rdata=%h, required no response",
                 bus.RSP_ERR, bus.RSP_RDATA);
      end else begin
        e = sb.pop_front();
        if (bus.RSP_ERR !== e.err || bus.RSP_RDATA !== e.rdata) begin
          errors++;
          $display("FAIL rsp_data: got err=%b rdata=%h, required err=%b rdata=%h",
                   bus.RSP_ERR, bus.RSP_RDATA, e.err, e.rdata);
        end
      end
    end
  end

  // One full transaction; k = WAIT cycle carrying the ACK, 0 = never acknowledged
  task automatic run_txn(input bit rd, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input int k, input logic [DW-1:0] mrd, input bit overlap,
                         input string name);
    sb_entry_t e;
    int  cs_n, busy_n, rsp_n, rsp_i, exp_cs, exp_busy, exp_rsp;
    bit  held_ok, done;
    checks++;
    if (bus.BUSY !== 1'b0) begin
      errors++;
      $display("FAIL %s_start_busy: got BUSY=%b, required 0", name, bus.BUSY);
    end
    bus.REQ_VALID = 1'b1;
    bus.REQ_READ  = rd;
    bus.REQ_WRITE = !rd;
    bus.REQ_ADDR  = addr;
    bus.REQ_WDATA = wd;
    if (rd && k > 0) exp_rdata = mrd;
    e.err   = (k == 0);
    e.rdata = exp_rdata;
    sb.push_back(e);
    cs_n = 0; busy_n = 0; rsp_n = 0; rsp_i = 0; held_ok = 1'b1; done = 1'b0;
    for (int i = 1; i <= 40 && !done; i++) begin
      @(negedge clk);
      if (i == 1) bus.REQ_VALID = 1'b0;
      if (overlap && i == 2) begin
        bus.REQ_VALID = 1'b1;
        bus.REQ_READ  = 1'b1;
        bus.REQ_WRITE = 1'b0;
        bus.REQ_ADDR  = ~addr;
        bus.REQ_WDATA = ~wd;
      end
      if (overlap && i == 3) bus.REQ_VALID = 1'b0;
      if (bus.BUSY === 1'b1) busy_n++;
      else done = 1'b1;
      if (bus.MEM_CS === 1'b1) begin
        cs_n++;
        if (bus.MEM_ADDR !== addr || bus.MEM_WDATA !== wd || bus.MEM_WE !== !rd)
          held_ok = 1'b0;
      end
      if (bus.RSP_VALID === 1'b1) begin
        rsp_n++;
        rsp_i = i;
      end
      bus.MEM_ACK   = (k > 0 && i == k + 1);
      bus.MEM_RDATA = bus.MEM_ACK ? mrd : $urandom();
    end
    bus.MEM_ACK = 1'b0;
    exp_cs   = (k > 0) ? k + 1 : TO + 1;
    exp_busy = exp_cs + 1;
    exp_rsp  = exp_cs + 1;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout: BUSY still high after 40 cycles, required return to idle", name);
    end
    checks++;
    if (cs_n !== exp_cs) begin
      errors++;
      $display("FAIL %s_cs_cycles: got %0d, required %0d", name, cs_n, exp_cs);
    end
    checks++;
    if (busy_n !== exp_busy) begin
      errors++;
      $display("FAIL %s_busy_cycles: got %0d, required %0d", name, busy_n, exp_busy);
    end
    checks++;
    if (rsp_n !== 1 || rsp_i !== exp_rsp) begin
      errors++;
      $display("FAIL %s_rsp_timing: got %0d pulses last at cycle %0d, required 1 at cycle %0d",
               name, rsp_n, rsp_i, exp_rsp);
    end
    checks++;
    if (!held_ok) begin
      errors++;
      $display("FAIL %s_mem_hold: MEM_ADDR/WDATA/WE changed under CS, required addr=%h wdata=%h we=%b",
               name, addr, wd, !rd);
    end
    checks++;
    if (bus.RSP_RDATA !== exp_rdata) begin
      errors++;
      $display("FAIL %s_rdata_hold: got %h, required %h", name, bus.RSP_RDATA, exp_rdata);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if (bus.BUSY !== 1'b0 || bus.MEM_CS !== 1'b0 || bus.MEM_WE !== 1'b0 ||
        bus.RSP_VALID !== 1'b0 || bus.RSP_ERR !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got busy=%b cs=%b we=%b vld=%b err=%b, required all 0",
               bus.BUSY, bus.MEM_CS, bus.MEM_WE, bus.RSP_VALID, bus.RSP_ERR);
    end
    checks++;
    if (bus.MEM_ADDR !== '0 || bus.MEM_WDATA !== '0 || bus.RSP_RDATA !== '0) begin
      errors++;
      $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h, required all 0",
               bus.MEM_ADDR, bus.MEM_WDATA, bus.RSP_RDATA);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_rdata = '0;
    @(negedge clk);
  endtask

  task automatic test_noop();
    int cs_seen;
    cs_seen = 0;
    for (int p = 0; p < 2; p++) begin
      bus.REQ_VALID = 1'b1;
      bus.REQ_READ  = (p == 0);
      bus.REQ_WRITE = (p == 0);
      bus.REQ_ADDR  = 26'h0000ABC;
      bus.REQ_WDATA = 32'hCAFEF00D;
      @(negedge clk);
      bus.REQ_VALID = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (bus.MEM_CS !== 1'b0 || bus.BUSY !== 1'b0) cs_seen++;
        @(negedge clk);
      end
    end
    checks++;
    if (cs_seen != 0) begin
      errors++;
      $display("FAIL noop_ignored: got %0d cycles with CS/BUSY high, required 0", cs_seen);
    end
  endtask

  task automatic test_spurious_ack();
    bus.MEM_ACK   = 1'b1;
    bus.MEM_RDATA = 32'hBAADF00D;
    @(negedge clk);
    bus.MEM_ACK = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.RSP_RDATA !== exp_rdata || bus.BUSY !== 1'b0) begin
      errors++;
      $display("FAIL spurious_ack: got rdata=%h busy=%b, required rdata=%h busy=0",
               bus.RSP_RDATA, bus.BUSY, exp_rdata);
    end
  endtask

  task automatic test_reset_mid_wait();
    bus.REQ_VALID = 1'b1;
    bus.REQ_READ  = 1'b0;
    bus.REQ_WRITE = 1'b1;
    bus.REQ_ADDR  = 26'h2AAAAAA;
    bus.REQ_WDATA = 32'h55AA55AA;
    @(negedge clk);
    bus.REQ_VALID = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.MEM_CS !== 1'b1 || bus.MEM_WE !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_precond: got cs=%b we=%b, required 1 1", bus.MEM_CS, bus.MEM_WE);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.BUSY !== 1'b0 || bus.MEM_CS !== 1'b0 || bus.MEM_WE !== 1'b0 ||
        bus.RSP_VALID !== 1'b0 || bus.RSP_ERR !== 1'b0 || bus.MEM_ADDR !== '0 ||
        bus.MEM_WDATA !== '0 || bus.RSP_RDATA !== '0) begin
      errors++;
      $display("FAIL rst_mid_async: got busy=%b cs=%b we=%b vld=%b err=%b addr=%h wd=%h rd=%h, required all 0",
               bus.BUSY, bus.MEM_CS, bus.MEM_WE, bus.RSP_VALID, bus.RSP_ERR,
               bus.MEM_ADDR, bus.MEM_WDATA, bus.RSP_RDATA);
    end
    exp_rdata = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    run_txn(1'b1, 26'h0000123, 32'h0, 2, 32'h600DCAFE, 1'b0, "rst_fresh_read");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_rdata = '0;
    bus.REQ_VALID = 1'b0;
    bus.REQ_READ  = 1'b0;
    bus.REQ_WRITE = 1'b0;
    bus.REQ_ADDR  = '0;
    bus.REQ_WDATA = '0;
    bus.MEM_RDATA = '0;
    bus.MEM_ACK   = 1'b0;

    test_reset();
    run_txn(1'b1, 26'h0001000, 32'h0, 1, 32'hDEADBEEF, 1'b0, "read_k1");
    run_txn(1'b0, 26'h3FFFFFF, 32'h12345678, 5, 32'h0, 1'b0, "write_k5");
    run_txn(1'b1, 26'h0000040, 32'h0, 0, 32'h0, 1'b0, "timeout");
    test_spurious_ack();
    run_txn(1'b1, 26'h0000044, 32'h0, 3, 32'hA5A5C3C3, 1'b0, "read_after_to");
    test_noop();
    run_txn(1'b1, 26'h1234567, 32'h0F0F0F0F, 2, 32'h13572468, 1'b1, "overlap");
    run_txn(1'b1, 26'h0000080, 32'h0, TO, 32'hFEEDFACE, 1'b0, "ack_last");
    run_txn(1'b0, 26'h0000084, 32'h87654321, 1, 32'h0, 1'b0, "b2b_wr");
    run_txn(1'b1, 26'h0000088, 32'h0, 1, 32'h11223344, 1'b0, "b2b_rd");
    test_spurious_ack();
    test_reset_mid_wait();

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d outstanding responses, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
